// File: rtl/seq_booth_multiplier_pkg.sv
// Shared definitions for the sequential radix-2 Booth multiplier.
//   MUL_WIDTH_DEFAULT : default operand width used by the datapath
//   mul_state_e       : control FSM state encoding
package seq_booth_multiplier_pkg;

    localparam int unsigned MUL_WIDTH_DEFAULT = 32;

    typedef enum logic [1:0] {
        MUL_IDLE = 2'd0,
        MUL_RUN  = 2'd1,
        MUL_DONE = 2'd2
    } mul_state_e;

endpackage

// File: rtl/seq_booth_multiplier_booth_step.sv
// One combinational radix-2 Booth step: conditional add/subtract of the
// multiplicand into the accumulator, then arithmetic right shift of {A,Q,q_-1}.
//   a_i/a_o     : accumulator A (WIDTH+2 bits) before/after the step
//   q_i/q_o     : multiplier register Q (WIDTH+1 bits) before/after the step
//   qm1_i/qm1_o : Booth guard bit q_-1 before/after the step
//   m_i         : extended multiplicand M (WIDTH+1 bits)
module seq_booth_multiplier_booth_step #(
    parameter int unsigned WIDTH = 32
) (
    input  logic [WIDTH+1:0] a_i,
    input  logic [WIDTH:0]   q_i,
    input  logic             qm1_i,
    input  logic [WIDTH:0]   m_i,
    output logic [WIDTH+1:0] a_o,
    output logic [WIDTH:0]   q_o,
    output logic             qm1_o
);

    logic [WIDTH+1:0] m_ext;
    logic [WIDTH+1:0] a_sum;

    // Booth recode on {Q[0],q_-1}, then shift the whole {A,Q,q_-1} right by one
    always_comb begin
        m_ext = {m_i[WIDTH], m_i};
        a_sum = a_i;
        case ({q_i[0], qm1_i})
            2'b01:   a_sum = a_i + m_ext;
            2'b10:   a_sum = a_i - m_ext;
            default: a_sum = a_i;
        endcase
        a_o   = {a_sum[WIDTH+1], a_sum[WIDTH+1:1]};
        q_o   = {a_sum[0], q_i[WIDTH:1]};
        qm1_o = q_i[0];
    end

endmodule

// File: rtl/seq_booth_multiplier.sv
// Multi-cycle radix-2 Booth multiplier, signed or unsigned, full-width product.
//   clk       : clock, rising edge
//   rst       : asynchronous active-high reset
//   start     : request, accepted only while not busy
//   is_signed : 1 = two's complement operands, 0 = unsigned (sampled with start)
//   a, b      : multiplicand / multiplier, sampled on the accepting edge
//   busy      : high while the operation is stepping
//   done      : one-cycle completion pulse
//   y         : 2*WIDTH-bit product, held until the next completion
module seq_booth_multiplier
    import seq_booth_multiplier_pkg::*;
#(
    parameter int unsigned WIDTH = MUL_WIDTH_DEFAULT
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               is_signed,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               busy,
    output logic               done,
    output logic [2*WIDTH-1:0] y
);

    localparam int unsigned CNT_W = $clog2(WIDTH + 1);

    mul_state_e         state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [WIDTH+1:0]   acc_q, acc_d;
    logic [WIDTH:0]     mlr_q, mlr_d;
    logic               qm1_q, qm1_d;
    logic [WIDTH:0]     mcand_q, mcand_d;
    logic [2*WIDTH-1:0] y_q, y_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;

    logic [WIDTH+1:0]   acc_step;
    logic [WIDTH:0]     mlr_step;
    logic               qm1_step;

    seq_booth_multiplier_booth_step #(
        .WIDTH (WIDTH)
    ) u_booth_step (
        .a_i   (acc_q),
        .q_i   (mlr_q),
        .qm1_i (qm1_q),
        .m_i   (mcand_q),
        .a_o   (acc_step),
        .q_o   (mlr_step),
        .qm1_o (qm1_step)
    );

    // Next-state, datapath and output decode
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        acc_d   = acc_q;
        mlr_d   = mlr_q;
        qm1_d   = qm1_q;
        mcand_d = mcand_q;
        y_d     = y_q;

        case (state_q)
            MUL_IDLE, MUL_DONE: begin
                if (start) begin
                    state_d = MUL_RUN;
                    cnt_d   = CNT_W'(WIDTH);
                    acc_d   = '0;
                    qm1_d   = 1'b0;
                    mcand_d = is_signed ? {a[WIDTH-1], a} : {1'b0, a};
                    mlr_d   = is_signed ? {b[WIDTH-1], b} : {1'b0, b};
                end else begin
                    state_d = MUL_IDLE;
                end
            end
            MUL_RUN: begin
                acc_d = acc_step;
                mlr_d = mlr_step;
                qm1_d = qm1_step;
                if (cnt_q == '0) begin
                    // Low 2*WIDTH bits of {A,Q} after the final shift
                    y_d     = {acc_step[WIDTH-2:0], mlr_step};
                    state_d = MUL_DONE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: state_d = MUL_IDLE;
        endcase

        // Status flags registered from the next state so they track state_q exactly
        busy_d = (state_d == MUL_RUN);
        done_d = (state_d == MUL_DONE);
    end

    // State and datapath registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= MUL_IDLE;
            cnt_q   <= '0;
            acc_q   <= '0;
            mlr_q   <= '0;
            qm1_q   <= 1'b0;
            mcand_q <= '0;
            y_q     <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            mlr_q   <= mlr_d;
            qm1_q   <= qm1_d;
            mcand_q <= mcand_d;
            y_q     <= y_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign y    = y_q;

endmodule

// File: tb/tb_seq_booth_multiplier.sv
// Self-checking bench for seq_booth_multiplier: a 32-bit and an 8-bit instance
// checked against plain-arithmetic product references.
module tb_seq_booth_multiplier;

    logic        clk = 1'b0;
    logic        rst = 1'b1;

    logic        start = 1'b0;
    logic        is_signed = 1'b0;
    logic [31:0] a = '0;
    logic [31:0] b = '0;
    logic        busy;
    logic        done;
    logic [63:0] y;

    logic        start8 = 1'b0;
    logic        is_signed8 = 1'b0;
    logic [7:0]  a8 = '0;
    logic [7:0]  b8 = '0;
    logic        busy8;
    logic        done8;
    logic [15:0] y8;

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    seq_booth_multiplier #(.WIDTH(32)) dut (
        .clk(clk), .rst(rst), .start(start), .is_signed(is_signed),
        .a(a), .b(b), .busy(busy), .done(done), .y(y)
    );

    seq_booth_multiplier #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst), .start(start8), .is_signed(is_signed8),
        .a(a8), .b(b8), .busy(busy8), .done(done8), .y(y8)
    );

    function automatic logic [63:0] ref32(input logic sgn, input logic [31:0] av, input logic [31:0] bv);
        logic [63:0] ea, eb;
        ea = sgn ? {{32{av[31]}}, av} : {32'd0, av};
        eb = sgn ? {{32{bv[31]}}, bv} : {32'd0, bv};
        return ea * eb;
    endfunction

    function automatic logic [15:0] ref8(input logic sgn, input logic [7:0] av, input logic [7:0] bv);
        logic [15:0] ea, eb;
        ea = sgn ? {{8{av[7]}}, av} : {8'd0, av};
        eb = sgn ? {{8{bv[7]}}, bv} : {8'd0, bv};
        return ea * eb;
    endfunction

    // Issue one 32-bit op; report result, cycles-to-done and busy cycle count
    task automatic op32(input logic sgn, input logic [31:0] av, input logic [31:0] bv,
                        output logic [63:0] yv, output int lat, output int bcnt);
        @(negedge clk);
        is_signed = sgn; a = av; b = bv; start = 1'b1;
        @(negedge clk);
        start = 1'b0; a = $urandom; b = $urandom; is_signed = 1'($urandom);
        lat = 0; bcnt = 0;
        for (int i = 1; i <= 100; i++) begin
            if (busy) bcnt++;
            if (done) begin lat = i; break; end
            @(negedge clk);
        end
        yv = y;
        total++;
        if (lat == 0) begin
            bad++;
            $display("FAIL op32_timeout: done never seen, got lat=%0d required <=100", lat);
        end
    endtask

    task automatic test_reset();
        #3;
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b required 0", busy); end
        total++; if (done !== 1'b0) begin bad++; $display("FAIL reset_done: got %b required 0", done); end
        total++; if (y !== 64'd0) begin bad++; $display("FAIL reset_y: got %h required 0", y); end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_basic();
        logic [63:0] r; int lat, bc;
        op32(1'b1, 32'd5, 32'd7, r, lat, bc);
        total++; if (r !== 64'd35) begin bad++; $display("FAIL basic_y: got %h required %h", r, 64'd35); end
        total++; if (lat !== 34) begin bad++; $display("FAIL basic_latency: got %0d required 34", lat); end
        total++; if (bc !== 33) begin bad++; $display("FAIL basic_busy_cycles: got %0d required 33", bc); end
    endtask

    task automatic test_negative();
        logic [63:0] r; int lat, bc;
        op32(1'b1, -32'sd5, 32'd9, r, lat, bc);
        total++; if (r !== 64'hFFFF_FFFF_FFFF_FFD3) begin bad++; $display("FAIL neg_signed: got %h required %h", r, 64'hFFFF_FFFF_FFFF_FFD3); end
        op32(1'b0, -32'sd5, 32'd9, r, lat, bc);
        total++; if (r !== 64'h8_FFFF_FFD3) begin bad++; $display("FAIL neg_unsigned: got %h required %h", r, 64'h8_FFFF_FFD3); end
    endtask

    task automatic test_corners();
        logic [63:0] r; int lat, bc;
        op32(1'b1, 32'h8000_0000, 32'h8000_0000, r, lat, bc);
        total++; if (r !== 64'h4000_0000_0000_0000) begin bad++; $display("FAIL min_min: got %h required %h", r, 64'h4000_0000_0000_0000); end
        op32(1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, r, lat, bc);
        total++; if (r !== 64'hFFFF_FFFE_0000_0001) begin bad++; $display("FAIL umax_umax: got %h required %h", r, 64'hFFFF_FFFE_0000_0001); end
        op32(1'b1, 32'h7FFF_FFFF, 32'h8000_0000, r, lat, bc);
        total++; if (r !== ref32(1'b1, 32'h7FFF_FFFF, 32'h8000_0000)) begin bad++; $display("FAIL max_min: got %h required %h", r, ref32(1'b1, 32'h7FFF_FFFF, 32'h8000_0000)); end
        op32(1'b1, 32'd0, 32'hDEAD_BEEF, r, lat, bc);
        total++; if (r !== 64'd0) begin bad++; $display("FAIL zero_a: got %h required 0", r); end
    endtask

    task automatic test_random32();
        logic [63:0] r; int lat, bc;
        logic [31:0] av, bv; logic sgn;
        for (int i = 0; i < 24; i++) begin
            av = $urandom; bv = $urandom; sgn = 1'(i);
            op32(sgn, av, bv, r, lat, bc);
            total++;
            if (r !== ref32(sgn, av, bv)) begin
                bad++;
                $display("FAIL rand32 s=%0d a=%h b=%h: got %h required %h", sgn, av, bv, r, ref32(sgn, av, bv));
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] a1, b1, a2, b2;
        int lat2;
        bit seen;
        a1 = 32'h1234_5678; b1 = 32'hFEDC_BA98; a2 = 32'h0BAD_F00D; b2 = 32'h0000_1001;
        @(negedge clk);
        is_signed = 1'b1; a = a1; b = b1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (5) @(negedge clk);
        // Intruding request while busy must be ignored
        is_signed = 1'b0; a = 32'hFFFF_FFFF; b = 32'h7777_7777; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL ignore_busy: got %b required 1", busy); end
        seen = 0;
        for (int i = 0; i < 100; i++) begin
            if (done) begin seen = 1; break; end
            @(negedge clk);
        end
        total++; if (!seen) begin bad++; $display("FAIL b2b_first_timeout: got no done required done"); end
        total++; if (y !== ref32(1'b1, a1, b1)) begin bad++; $display("FAIL ignore_result: got %h required %h", y, ref32(1'b1, a1, b1)); end
        // Start during the DONE cycle
        is_signed = 1'b0; a = a2; b = b2; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        total++; if (busy !== 1'b1 || done !== 1'b0) begin bad++; $display("FAIL b2b_busy_rise: got busy=%b done=%b required busy=1 done=0", busy, done); end
        lat2 = 0;
        for (int i = 1; i <= 100; i++) begin
            if (done) begin lat2 = i; break; end
            @(negedge clk);
        end
        total++; if (lat2 !== 34) begin bad++; $display("FAIL b2b_latency: got %0d required 34", lat2); end
        total++; if (y !== ref32(1'b0, a2, b2)) begin bad++; $display("FAIL b2b_result: got %h required %h", y, ref32(1'b0, a2, b2)); end
    endtask

    task automatic test_reset_mid_run();
        bit seen;
        @(negedge clk);
        is_signed = 1'b1; a = 32'h0000_0003; b = 32'h0000_0004; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (10) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL midrst_busy: got %b required 0", busy); end
        total++; if (done !== 1'b0) begin bad++; $display("FAIL midrst_done: got %b required 0", done); end
        total++; if (y !== 64'd0) begin bad++; $display("FAIL midrst_y: got %h required 0", y); end
        @(negedge clk);
        rst = 1'b0;
        seen = 0;
        repeat (40) begin
            @(negedge clk);
            if (done || busy) seen = 1;
        end
        total++; if (seen) begin bad++; $display("FAIL midrst_no_done: got activity=1 required 0"); end
    endtask

    task automatic test_width8_random();
        logic [7:0] av, bv; logic sgn; bit seen;
        for (int n = 0; n < 1000; n++) begin
            av = 8'($urandom); bv = 8'($urandom); sgn = 1'($urandom);
            if (n == 0) begin av = 8'h80; bv = 8'h80; sgn = 1'b1; end
            if (n == 1) begin av = 8'hFF; bv = 8'hFF; sgn = 1'b0; end
            @(negedge clk);
            is_signed8 = sgn; a8 = av; b8 = bv; start8 = 1'b1;
            @(negedge clk);
            start8 = 1'b0; a8 = 8'($urandom); b8 = 8'($urandom);
            seen = 0;
            for (int i = 0; i < 40; i++) begin
                if (done8) begin seen = 1; break; end
                @(negedge clk);
            end
            total++;
            if (!seen || y8 !== ref8(sgn, av, bv)) begin
                bad++;
                $display("FAIL w8 s=%0d a=%h b=%h: got %h (done=%0d) required %h", sgn, av, bv, y8, seen, ref8(sgn, av, bv));
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_negative();
        test_corners();
        test_random32();
        test_back_to_back();
        test_reset_mid_run();
        test_width8_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
